team_06_delay_line_ctrl: RTL and testbench

- Sequences the shared delay-line SRAM for the echo/reverb datapath, once per audio sample.
- Per sample strobe it:
  1. Reads the sample `offset` positions behind the write pointer and presents it as `past_output`.
  2. Waits for the echo/reverb stage to produce its registered `save_audio`.
  3. Writes `save_audio` at the write pointer and advances the pointer.
- Sits between the echo/reverb block and the SRAM request/ack port.

---
 rtl/team_06_delay_line_ctrl.sv | 129 ++++++++++++
 tb/tb_team_06_delay_line_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_delay_line_ctrl.sv
// Delay-line SRAM sequencer for the echo/reverb datapath.
// Each sample strobe produces one read of the sample `offset` positions
// behind the write pointer (skipped while the buffer is too short), waits
// one cycle for the echo stage's register, then writes the new value back.
module team_06_delay_line_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] save_audio,
  output logic [DATA_W-1:0] past_output,
  output logic              past_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, RD, SETTLE, LATCH, WR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] fill_cnt_q;
  logic [DATA_W-1:0] past_output_q;
  logic              past_valid_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              overrun_q;
  logic              skip;
  logic              ack_ok;

  // The read is pointless when the delay is zero or reaches past the
  // oldest sample written since reset; the strobe-cycle offset decides.
  assign skip   = (offset == '0) || (fill_cnt_q < offset);
  // Acks only count while a request is outstanding.
  assign ack_ok = mem_req_q & mem_ack;
  assign busy   = (state_q != IDLE);

  assign past_output = past_output_q;
  assign past_valid  = past_valid_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign overrun     = overrun_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid) state_d = skip ? SETTLE : RD;
      RD:      if (ack_ok) state_d = SETTLE;
      SETTLE:  state_d = LATCH;
      LATCH:   state_d = WR;
      WR:      if (ack_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered SRAM port, past sample, pointers and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      past_output_q <= '0;
      past_valid_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      past_valid_q <= 1'b0;
      overrun_q    <= sample_valid && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            if (skip) begin
              past_output_q <= '0;
              past_valid_q  <= 1'b1;
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= wr_ptr_q - offset;
            end
          end
        end
        RD: begin
          if (ack_ok) begin
            mem_req_q     <= 1'b0;
            past_output_q <= mem_rdata;
            past_valid_q  <= 1'b1;
          end
        end
        LATCH: begin
          mem_wdata_q <= save_audio;
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= wr_ptr_q;
        end
        WR: begin
          if (ack_ok) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
            if (fill_cnt_q != '1) fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_team_06_delay_line_ctrl.sv
// Bench for the delay-line sequencer: an SRAM model answers requests with a
// chosen ack delay, and a circular-buffer model predicts every read address,
// past sample and write.
module tb_team_06_delay_line_ctrl;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic [AW-1:0] offset;
  logic [DW-1:0] save_audio;
  logic [DW-1:0] past_output;
  logic          past_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          overrun;

  team_06_delay_line_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .offset(offset),
    .save_audio(save_audio), .past_output(past_output), .past_valid(past_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int wr_m;
  int fill_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request attributes must not move while a request stays up.
  logic          prev_req = 1'b0;
  logic          prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  always @(negedge clk) begin
    if (!rst && prev_req && mem_req) begin
      chk("stable_we", mem_we, prev_we);
      chk("stable_addr", mem_addr, prev_addr);
      if (mem_we) chk("stable_wdata", mem_wdata, prev_wdata);
    end
    prev_req   = mem_req;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  // One sample transaction; called at a negedge with the DUT idle.
  task automatic do_sample(input int off, input logic [DW-1:0] sav, input int dly,
                           input bit ovr, input bit verbose);
    bit            skip_e;
    logic [AW-1:0] raddr_e;
    logic [DW-1:0] past_e;
    logic [AW-1:0] waddr_e;
    skip_e  = (off == 0) || (fill_m < off);
    raddr_e = AW'((wr_m - off + DEPTH) % DEPTH);
    past_e  = skip_e ? '0 : ref_mem[raddr_e];
    waddr_e = AW'(wr_m);

    chk("idle_busy", busy, 1'b0);
    offset = AW'(off);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    offset = AW'($urandom);
    chk("busy_after_strobe", busy, 1'b1);
    if (!skip_e) begin
      chk("rd_req", mem_req, 1'b1);
      chk("rd_we", mem_we, 1'b0);
      chk("rd_addr", mem_addr, raddr_e);
      chk("pv_early", past_valid, 1'b0);
      repeat (dly) @(negedge clk);
      chk("rd_req_wait", mem_req, 1'b1);
      mem_ack   = 1'b1;
      mem_rdata = sram[mem_addr];
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = DW'($urandom);
      chk("rd_req_drop", mem_req, 1'b0);
    end else begin
      chk("skip_no_req", mem_req, 1'b0);
    end
    chk("past_valid", past_valid, 1'b1);
    chk("past_output", past_output, past_e);
    save_audio = sav;
    @(negedge clk);
    chk("pv_pulse", past_valid, 1'b0);
    chk("wr_req_early", mem_req, 1'b0);
    @(negedge clk);
    chk("wr_req", mem_req, 1'b1);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_addr", mem_addr, waddr_e);
    chk("wr_data", mem_wdata, sav);
    save_audio = DW'($urandom);
    if (ovr) sample_valid = 1'b1;
    for (int i = 1; i <= dly; i++) begin
      @(negedge clk);
      if (ovr && i == 1) begin
        sample_valid = 1'b0;
        chk("overrun", overrun, 1'b1);
      end else if (ovr && i == 2) begin
        chk("overrun_pulse", overrun, 1'b0);
      end
      chk("wr_req_wait", mem_req, 1'b1);
    end
    mem_ack = 1'b1;
    sram[mem_addr] = mem_wdata;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("wr_req_drop", mem_req, 1'b0);
    chk("idle_after_wr", busy, 1'b0);
    ref_mem[wr_m] = sav;
    wr_m = (wr_m + 1) % DEPTH;
    if (fill_m < DEPTH - 1) fill_m++;
    if (verbose)
      $display("txn off=%0d skip=%0b raddr=%0d past=%02h waddr=%0d wdata=%02h dly=%0d",
               off, skip_e, raddr_e, past_e, waddr_e, sav, dly);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    wr_m = 0;
    fill_m = 0;
    rst = 1'b1;
    sample_valid = 1'b0;
    offset = '0;
    save_audio = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;

    // Reset state.
    @(negedge clk);
    chk("rst_past_output", past_output, '0);
    chk("rst_past_valid", past_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Stray ack while idle does nothing.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_req", mem_req, 1'b0);
    chk("stray_busy", busy, 1'b0);
    chk("stray_pv", past_valid, 1'b0);
    $display("txn stray ack in idle");

    // First sample on an empty buffer, then preload and a real read.
    do_sample(8000, 8'h5A, 1, 1'b0, 1'b1);
    do_sample(1, 8'h33, 1, 1'b0, 1'b1);
    do_sample(5, 8'h77, 1, 1'b0, 1'b1);
    do_sample(2, 8'hC4, 1, 1'b0, 1'b1);
    // Slow SRAM plus a strobe during the write.
    do_sample(3, 8'h9E, 4, 1'b1, 1'b1);

    // Reset in the middle of a read.
    offset = AW'(1);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("pre_rst_rd_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", mem_req, 1'b0);
    chk("midrst_pv", past_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wr_m = 0;
    fill_m = 0;
    $display("txn reset during read");
    @(negedge clk);
    do_sample(8000, 8'h5A, 1, 1'b0, 1'b1);

    // Random traffic until the buffer is saturated and the pointer has wrapped to 5.
    while (!(fill_m == DEPTH - 1 && wr_m == 5))
      do_sample(int'($urandom_range(0, 40)), DW'($urandom), 1, 1'b0, 1'b0);
    $display("txn bulk done wr=%0d fill=%0d", wr_m, fill_m);

    // Wrapped read address, zero offset on a full buffer, maximum offset.
    do_sample(8000, DW'($urandom), 1, 1'b0, 1'b1);
    do_sample(0, DW'($urandom), 2, 1'b0, 1'b1);
    do_sample(DEPTH - 1, DW'($urandom), 3, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
